acc_resp_adapter: RTL and testbench
===================================

# acc_resp_adapter

Responder-side endpoint of the accelerator interface. Accepts offloaded instructions from the interconnect, registers them toward the accelerator datapath, and records each requester ID that expects write-back in an in-order ID queue. Tags returning accelerator results with the matching ID and sends them back to the requester. It sits between the interconnect's responder port and one accelerator core, as either a private or a shared responder.

## Interface

**Parameters**
- `NumReq`, 1: number of requesters on the interconnect.
- `DataWidth`, 32: operand and result width.
- `Depth`, 4: maximum outstanding write-back requests (≥1).
- `IdxWidth`, derived: `NumReq > 1 ? $clog2(NumReq) : 1`.
- `IdWidth`, derived: `5 + IdxWidth` (rd[4:0] in the LSBs, requester index in the MSBs).

**Ports**
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  synchronous active-low reset.
- `req_valid_i` / `req_ready_o`  in/out  1  request handshake.
- `req_id_i`  in  IdWidth  requester ID.
- `req_instr_i`  in  32  offloaded instruction.
- `req_rs1_i`, `req_rs2_i`  in  DataWidth  source operands.
- `req_wb_i`  in  1  response expected.
- `acc_valid_o` / `acc_ready_i`  out/in  1  accelerator issue handshake.
- `acc_instr_o`  out  32  registered instruction.
- `acc_rs1_o`, `acc_rs2_o`  out  DataWidth  registered operands.
- `acc_res_valid_i` / `acc_res_ready_o`  in/out  1  accelerator result handshake.
- `acc_res_data_i`  in  DataWidth  result.
- `acc_res_error_i`  in  1  result error.
- `resp_valid_o` / `resp_ready_i`  out/in  1  response handshake.
- `resp_id_o`  out  IdWidth  ID of the response.
- `resp_data_o`  out  DataWidth  response data.
- `resp_error_o`  out  1  response error.
- `outstanding_o`  out  $clog2(Depth+1)  number of IDs queued.
- `orphan_o`  out  1  sticky orphan-result flag (see Configuration).

## Operation

**Reset values**
- Synchronous reset clears all valids, the queue, `outstanding_o` and `orphan_o`.
- All data and ID outputs reset to 0.

**Request stage**
- One-entry pipeline register.
- `req_ready_o = (!acc_valid_o || acc_ready_i) && (!req_wb_i || outstanding_o < Depth)`.
- On a request handshake:
  - the register loads instr, rs1 and rs2, and `acc_valid_o` sets;
  - if `req_wb_i` is set, `req_id_i` is pushed to the queue.
- `acc_valid_o` clears on an accelerator handshake with no new request in the same cycle.
- Push is decided only on current count; a pop in the same cycle does not free space for a push.
- Requests with `req_wb_i=0` never block on a full queue and are never answered.

**Response stage**
- Output register plus in-order FIFO of depth `Depth`.
- `acc_res_ready_o = (!resp_valid_o || resp_ready_i) && (outstanding_o != 0)`, or per Configuration.
- On a result handshake:
  - pop the head ID;
  - load `resp_id_o`, `resp_data_o` and `resp_error_o`;
  - set `resp_valid_o`.
- `resp_valid_o` clears on a response handshake with no new result in the same cycle.
- Responses leave in request order. The accelerator must return results in order.

**Counter**
- push only: +1. Pop only: −1. Push and pop together: unchanged.
- Never exceeds `Depth` and never underflows.
- The FIFO read and write pointers wrap modulo `Depth`.

**Stability**
- While a valid output is stalled (valid=1, ready=0), its payload holds constant.

## Timing

- Request to `acc_valid_o`: 1 cycle.
- Result to `resp_valid_o`: 1 cycle.
- Sustained throughput is 1 transaction per cycle on both paths when ready stays high.
- No combinational path from `req_valid_i` to `acc_valid_o`, or from `acc_res_valid_i` to `resp_valid_o`.
- `req_ready_o` depends combinationally on `acc_ready_i` and `req_wb_i`.
- `acc_res_ready_o` depends combinationally on `resp_ready_i`.
- Reset asserted mid-transaction discards all in-flight requests, queued IDs and pending responses on the next edge.

## Configuration

Macro `ACC_RESP_ADAPTER_ORPHAN_DROP_EN`.

- **Defined:** `acc_res_ready_o` ignores the empty queue and equals `!resp_valid_o || resp_ready_i`.
  - A result accepted while `outstanding_o == 0` is an orphan. It is discarded: no response and no counter change.
  - `orphan_o` sets the following cycle and stays set until reset.
  - A push in the same cycle as an orphan still increments the counter.
- **Undefined:** `acc_res_ready_o` stays low while the queue is empty, and `orphan_o` is tied to 0.

## Test plan

1. **Single write-back.** Request id=0x23, rs1=5, wb=1. `acc_valid_o` goes high 1 cycle later and `outstanding_o=1`. Result 0xAB → next cycle `resp_valid_o=1`, `resp_id_o=0x23`, `resp_data_o=0xAB`, and `outstanding_o=0`.
2. **Full queue.** Depth=4 with `acc_ready_i` always 1. Push 4 wb requests → `outstanding_o=4`. A 5th wb=1 request sees `req_ready_o=0`. A concurrent wb=0 request is accepted.
3. **Ordering and wrap.** Issue 10 wb requests, ids 0–9, with a random `resp_ready_i`. Responses come back ids 0–9 in order, and no data changes while stalled.
4. **Push and pop together.** With count=2, a request and a result handshake in the same cycle leave count=2. The response carries the old head ID.
5. **Orphan result.** Empty queue, result valid. Without the macro, `acc_res_ready_o=0` indefinitely. With the macro, the result is accepted, no response is produced, and `orphan_o=1` until `rst_ni=0`.
6. **Reset mid-operation.** With count=3 and `resp_valid_o=1`, assert `rst_ni=0` for 1 cycle. Next cycle all valids are 0 and `outstanding_o=0`.

Source files
------------

// File: rtl/acc_resp_adapter.sv
// Accelerator-interface responder: registers offloaded requests toward the core and tags results with in-order IDs.
// Optional build macro ACC_RESP_ADAPTER_ORPHAN_DROP_EN accepts and drops results that arrive with no queued ID.
`default_nettype none

module acc_resp_adapter #(
  parameter int unsigned NumReq    = 1,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  parameter int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1,
  parameter int unsigned IdWidth   = 5 + IdxWidth,
  parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IdWidth-1:0]   req_id_i,
  input  logic [31:0]          req_instr_i,
  input  logic [DataWidth-1:0] req_rs1_i,
  input  logic [DataWidth-1:0] req_rs2_i,
  input  logic                 req_wb_i,
  output logic                 acc_valid_o,
  input  logic                 acc_ready_i,
  output logic [31:0]          acc_instr_o,
  output logic [DataWidth-1:0] acc_rs1_o,
  output logic [DataWidth-1:0] acc_rs2_o,
  input  logic                 acc_res_valid_i,
  output logic                 acc_res_ready_o,
  input  logic [DataWidth-1:0] acc_res_data_i,
  input  logic                 acc_res_error_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [IdWidth-1:0]   resp_id_o,
  output logic [DataWidth-1:0] resp_data_o,
  output logic                 resp_error_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 orphan_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
  localparam logic [PtrWidth-1:0] PtrLast  = PtrWidth'(Depth - 1);

  logic                 r_acc_valid;
  logic [31:0]          r_acc_instr;
  logic [DataWidth-1:0] r_acc_rs1;
  logic [DataWidth-1:0] r_acc_rs2;

  logic                 r_resp_valid;
  logic [IdWidth-1:0]   r_resp_id;
  logic [DataWidth-1:0] r_resp_data;
  logic                 r_resp_error;

  logic [IdWidth-1:0]   r_id_q [Depth];
  logic [PtrWidth-1:0]  r_wptr;
  logic [PtrWidth-1:0]  r_rptr;
  logic [CntWidth-1:0]  r_count;

  logic w_acc_take;
  logic w_q_space;
  logic w_q_nonempty;
  logic w_resp_take;
  logic w_req_hs;
  logic w_push;
  logic w_res_hs;
  logic w_pop;

  // Space is judged on the current count only; a same-cycle pop never makes room.
  assign w_acc_take   = !r_acc_valid || acc_ready_i;
  assign w_q_space    = (r_count < DepthCnt);
  assign w_q_nonempty = (r_count != '0);
  assign w_resp_take  = !r_resp_valid || resp_ready_i;

  assign req_ready_o  = w_acc_take && (!req_wb_i || w_q_space);
  assign w_req_hs     = req_valid_i && req_ready_o;
  assign w_push       = w_req_hs && req_wb_i;

`ifdef ACC_RESP_ADAPTER_ORPHAN_DROP_EN
  logic w_orphan;
  logic r_orphan;

  assign acc_res_ready_o = w_resp_take;
  assign w_orphan        = w_res_hs && !w_q_nonempty;
  assign orphan_o        = r_orphan;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_orphan <= 1'b0;
    end else if (w_orphan) begin
      r_orphan <= 1'b1;
    end
  end
`else
  assign acc_res_ready_o = w_resp_take && w_q_nonempty;
  assign orphan_o        = 1'b0;
`endif

  assign w_res_hs = acc_res_valid_i && acc_res_ready_o;
  assign w_pop    = w_res_hs && w_q_nonempty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_acc_valid <= 1'b0;
      r_acc_instr <= '0;
      r_acc_rs1   <= '0;
      r_acc_rs2   <= '0;
    end else if (w_req_hs) begin
      r_acc_valid <= 1'b1;
      r_acc_instr <= req_instr_i;
      r_acc_rs1   <= req_rs1_i;
      r_acc_rs2   <= req_rs2_i;
    end else if (acc_ready_i) begin
      r_acc_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        r_id_q[i] <= '0;
      end
      r_wptr <= '0;
    end else if (w_push) begin
      r_id_q[r_wptr] <= req_id_i;
      r_wptr         <= (r_wptr == PtrLast) ? '0 : r_wptr + PtrWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rptr <= '0;
    end else if (w_pop) begin
      r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + PtrWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntWidth'(1);
        2'b01:   r_count <= r_count - CntWidth'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload loads only on a real pop, so an orphan never disturbs a stalled response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
      r_resp_error <= 1'b0;
    end else if (w_pop) begin
      r_resp_valid <= 1'b1;
      r_resp_id    <= r_id_q[r_rptr];
      r_resp_data  <= acc_res_data_i;
      r_resp_error <= acc_res_error_i;
    end else if (resp_ready_i) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign acc_valid_o   = r_acc_valid;
  assign acc_instr_o   = r_acc_instr;
  assign acc_rs1_o     = r_acc_rs1;
  assign acc_rs2_o     = r_acc_rs2;
  assign resp_valid_o  = r_resp_valid;
  assign resp_id_o     = r_resp_id;
  assign resp_data_o   = r_resp_data;
  assign resp_error_o  = r_resp_error;
  assign outstanding_o = r_count;

endmodule

`default_nettype wire

// File: tb/tb_acc_resp_adapter.sv
// Self-checking bench for acc_resp_adapter: directed steps plus random traffic against a queue-based model.
module tb_acc_resp_adapter;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int IDW   = 6;
  localparam int CW    = 3;
`ifdef ACC_RESP_ADAPTER_ORPHAN_DROP_EN
  localparam bit ORPHAN_EN = 1'b1;
`else
  localparam bit ORPHAN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_ni;
  logic           req_valid_i, req_ready_o, req_wb_i;
  logic [IDW-1:0] req_id_i;
  logic [31:0]    req_instr_i;
  logic [DW-1:0]  req_rs1_i, req_rs2_i;
  logic           acc_valid_o, acc_ready_i;
  logic [31:0]    acc_instr_o;
  logic [DW-1:0]  acc_rs1_o, acc_rs2_o;
  logic           acc_res_valid_i, acc_res_ready_o, acc_res_error_i;
  logic [DW-1:0]  acc_res_data_i;
  logic           resp_valid_o, resp_ready_i, resp_error_o;
  logic [IDW-1:0] resp_id_o;
  logic [DW-1:0]  resp_data_o;
  logic [CW-1:0]  outstanding_o;
  logic           orphan_o;

  acc_resp_adapter #(.NumReq(1), .DataWidth(DW), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_id_i(req_id_i),
    .req_instr_i(req_instr_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_wb_i(req_wb_i),
    .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i), .acc_instr_o(acc_instr_o),
    .acc_rs1_o(acc_rs1_o), .acc_rs2_o(acc_rs2_o),
    .acc_res_valid_i(acc_res_valid_i), .acc_res_ready_o(acc_res_ready_o),
    .acc_res_data_i(acc_res_data_i), .acc_res_error_i(acc_res_error_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
    .resp_data_o(resp_data_o), .resp_error_o(resp_error_o),
    .outstanding_o(outstanding_o), .orphan_o(orphan_o)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: transaction-level view of the adapter.
  bit             m_acc_valid;
  logic [31:0]    m_instr;
  logic [DW-1:0]  m_rs1, m_rs2;
  logic [IDW-1:0] m_idq [$];
  bit             m_resp_valid;
  logic [IDW-1:0] m_resp_id;
  logic [DW-1:0]  m_resp_data;
  bit             m_resp_err;
  bit             m_orphan;

  bit             g_req_hs;
  bit             g_resp_fire;
  logic [IDW-1:0] g_resp_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc_valid = 0; m_instr = '0; m_rs1 = '0; m_rs2 = '0;
    m_idq.delete();
    m_resp_valid = 0; m_resp_id = '0; m_resp_data = '0; m_resp_err = 0;
    m_orphan = 0;
  endtask

  task automatic idle();
    req_valid_i = 0; req_wb_i = 0; acc_res_valid_i = 0;
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic tick();
    bit er, ea, qhs, rhs;
    int sz;
    #1;
    sz = m_idq.size();
    er = (!m_acc_valid || acc_ready_i) && (!req_wb_i || sz < DEPTH);
    ea = (!m_resp_valid || resp_ready_i) && (ORPHAN_EN || sz != 0);
    chk("req_ready", req_ready_o, er);
    chk("res_ready", acc_res_ready_o, ea);
    qhs = req_valid_i && er;
    rhs = acc_res_valid_i && ea;
    g_req_hs    = qhs && rst_ni;
    g_resp_fire = m_resp_valid && resp_ready_i && rst_ni;
    g_resp_id   = resp_id_o;
    @(posedge clk);
    #1;
    if (!rst_ni) begin
      model_reset();
    end else begin
      if (rhs && sz != 0) begin
        m_resp_id    = m_idq.pop_front();
        m_resp_data  = acc_res_data_i;
        m_resp_err   = acc_res_error_i;
        m_resp_valid = 1;
      end else begin
        if (rhs) m_orphan = 1;
        if (resp_ready_i) m_resp_valid = 0;
      end
      if (qhs) begin
        m_acc_valid = 1;
        m_instr = req_instr_i; m_rs1 = req_rs1_i; m_rs2 = req_rs2_i;
        if (req_wb_i) m_idq.push_back(req_id_i);
      end else if (acc_ready_i) begin
        m_acc_valid = 0;
      end
    end
    chk("acc_valid",   acc_valid_o,   m_acc_valid);
    chk("acc_instr",   acc_instr_o,   m_instr);
    chk("acc_rs1",     acc_rs1_o,     m_rs1);
    chk("acc_rs2",     acc_rs2_o,     m_rs2);
    chk("resp_valid",  resp_valid_o,  m_resp_valid);
    chk("resp_id",     resp_id_o,     m_resp_id);
    chk("resp_data",   resp_data_o,   m_resp_data);
    chk("resp_error",  resp_error_o,  m_resp_err);
    chk("outstanding", outstanding_o, 64'(m_idq.size()));
    chk("orphan",      orphan_o,      m_orphan);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued, got;
    model_reset();
    rst_ni = 0; idle();
    req_id_i = '0; req_instr_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    acc_ready_i = 0; acc_res_data_i = '0; acc_res_error_i = 0; resp_ready_i = 0;
    @(negedge clk);
    tick(); tick();
    chk("rst_acc_valid", acc_valid_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_resp_data", resp_data_o, 0);
    chk("rst_orphan", orphan_o, 0);
    rst_ni = 1;

    // single write-back
    req_valid_i = 1; req_wb_i = 1; req_id_i = 6'h23; req_rs1_i = 5; req_rs2_i = 0;
    req_instr_i = $urandom; acc_ready_i = 1;
    tick();
    chk("t1_acc_valid", acc_valid_o, 1);
    chk("t1_outstanding", outstanding_o, 1);
    chk("t1_acc_rs1", acc_rs1_o, 5);
    idle(); acc_res_valid_i = 1; acc_res_data_i = 32'hAB; resp_ready_i = 0;
    tick();
    chk("t1_resp_valid", resp_valid_o, 1);
    chk("t1_resp_id", resp_id_o, 6'h23);
    chk("t1_resp_data", resp_data_o, 32'hAB);
    chk("t1_outstanding_0", outstanding_o, 0);
    idle(); resp_ready_i = 1;
    tick();

    // full queue
    acc_ready_i = 1;
    for (int i = 0; i < DEPTH; i++) begin
      req_valid_i = 1; req_wb_i = 1; req_id_i = IDW'(i + 1); req_instr_i = $urandom;
      tick();
    end
    chk("t2_full_count", outstanding_o, DEPTH);
    req_wb_i = 1; req_id_i = 6'h09;
    #1 chk("t2_full_block", req_ready_o, 0);
    tick();
    req_wb_i = 0; req_instr_i = 32'hC0DE_0005;
    #1 chk("t2_nowb_accept", req_ready_o, 1);
    tick();
    chk("t2_nowb_count", outstanding_o, DEPTH);
    chk("t2_nowb_instr", acc_instr_o, 32'hC0DE_0005);
    idle(); acc_res_valid_i = 1;
    for (int i = 0; i < DEPTH; i++) begin
      acc_res_data_i = $urandom; acc_res_error_i = 1'($urandom);
      tick();
    end
    idle();
    tick();
    chk("t2_drained", outstanding_o, 0);

    // ordering and pointer wrap with random backpressure
    issued = 0; got = 0;
    for (int c = 0; c < 400 && got < 10; c++) begin
      req_valid_i = (issued < 10); req_wb_i = 1; req_id_i = IDW'(issued);
      req_instr_i = $urandom; req_rs1_i = $urandom; req_rs2_i = $urandom;
      acc_ready_i = 1'($urandom); acc_res_valid_i = 1'($urandom);
      acc_res_data_i = $urandom; acc_res_error_i = 1'($urandom); resp_ready_i = 1'($urandom);
      tick();
      if (g_req_hs) issued++;
      if (g_resp_fire) begin
        chk("t3_order", g_resp_id, IDW'(got));
        got++;
      end
    end
    chk("t3_all_responses", got, 10);
    idle(); resp_ready_i = 1; acc_ready_i = 1;
    tick();

    // push and pop together at count=2
    req_valid_i = 1; req_wb_i = 1; req_id_i = 6'h11; tick();
    req_id_i = 6'h12; tick();
    chk("t4_count2", outstanding_o, 2);
    req_id_i = 6'h13; acc_res_valid_i = 1; acc_res_data_i = 32'h55;
    tick();
    chk("t4_count_same", outstanding_o, 2);
    chk("t4_head_id", resp_id_o, 6'h11);
    idle(); acc_res_valid_i = 1;
    tick(); tick();
    idle();
    tick();

    // result with empty queue
    acc_res_valid_i = 1; acc_res_data_i = 32'hDEAD; resp_ready_i = 1;
`ifdef ACC_RESP_ADAPTER_ORPHAN_DROP_EN
    tick();
    chk("t5_orphan_set", orphan_o, 1);
    chk("t5_no_resp", resp_valid_o, 0);
    chk("t5_count", outstanding_o, 0);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_orphan_sticky", orphan_o, 1);
    end
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_res_blocked", acc_res_ready_o, 0);
      chk("t5_no_resp", resp_valid_o, 0);
    end
    idle();
`endif

    // reset in the middle of traffic
    req_valid_i = 1; req_wb_i = 1; acc_ready_i = 1;
    for (int i = 1; i <= 3; i++) begin
      req_id_i = IDW'(i); tick();
    end
    req_id_i = 6'h04; acc_res_valid_i = 1; resp_ready_i = 0;
    tick();
    chk("t6_count3", outstanding_o, 3);
    chk("t6_resp_valid", resp_valid_o, 1);
    rst_ni = 0;
    tick();
    rst_ni = 1; idle();
    chk("t6_acc_valid", acc_valid_o, 0);
    chk("t6_resp_valid0", resp_valid_o, 0);
    chk("t6_count0", outstanding_o, 0);
    chk("t6_orphan0", orphan_o, 0);
    tick();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      req_valid_i = ($urandom_range(0, 3) != 0); req_wb_i = 1'($urandom);
      req_id_i = IDW'($urandom); req_instr_i = $urandom;
      req_rs1_i = $urandom; req_rs2_i = $urandom;
      acc_ready_i = ($urandom_range(0, 3) != 0);
      acc_res_valid_i = 1'($urandom); acc_res_data_i = $urandom; acc_res_error_i = 1'($urandom);
      resp_ready_i = ($urandom_range(0, 2) != 0);
      rst_ni = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_ni = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
